npu_ctrl: RTL and testbench
===========================

# npu_ctrl

NPU-side responder for the matrix-multiply handshake driven by the decode stage. It waits for `EN_NPU`, then lets the three matrix base addresses settle and latches them. It reads matrices A and B from the NPU's dedicated data-memory port, computes C = A×B with one multiply-accumulate per cycle, writes C back, and ends the operation with a one-cycle `ack`. Its `mem_wr_en`/`mem_wr_addr` outputs feed the decode stage's critical-address hazard check.

## Interface
Parameters:
- `N`, 4: matrix dimension (N×N, row-major, one 32-bit word per element).
- `ADDR_WAIT`, 4: cycles from `EN_NPU` sampled high to address latch.

Ports:
- `clk_50`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `EN_NPU`, in, 1: start request, held high until `ack`.
- `matA_addr` / `matB_addr` / `matC_addr`, in, 10 each: word base addresses. Valid from the `ADDR_WAIT`-th cycle onward.
- `mem_rd_en`, out, 1: read request.
- `mem_rd_addr`, out, 10: read address.
- `mem_rdata`, in, 32: read data, valid exactly 1 cycle after `mem_rd_en`.
- `mem_wr_en`, out, 1: write strobe.
- `mem_wr_addr`, out, 10: write address.
- `mem_wdata`, out, 32: write data.
- `busy`, out, 1: high in any state other than IDLE.
- `ack`, out, 1: one-cycle done pulse.

## Operation
- States: IDLE → WAIT_ADDR → LOAD → COMPUTE → DONE → IDLE.
- IDLE:
  - Leaves on a rising edge of `EN_NPU`: current sample 1, previous sample 0.
  - A level held high after DONE does not restart the block.
- WAIT_ADDR:
  - Counts `ADDR_WAIT` cycles.
  - Latches all three bases on the last cycle.
- LOAD:
  - Issues 2N² reads, one per cycle: A elements base+k, then B elements base+k, for k = 0..N²−1.
  - Each returning word is captured into the local buffer one cycle later.
  - Adds one drain cycle, so the state lasts 2N²+1 cycles.
- COMPUTE, for each (i,j) in row-major order:
  - N MAC cycles: acc ← (k==0 ? 0 : acc) + A[i][k]·B[k][j].
  - Then one write cycle: `mem_wr_en`=1, `mem_wr_addr`=C_base+i·N+j, `mem_wdata`=acc.
  - Duration is N²(N+1) cycles.
- DONE: `ack`=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - The product is the low 32 bits of the signed 32×32 multiply.
  - The accumulator is 32-bit and wraps; there is no saturation.
- Address arithmetic is mod 1024, so base+offset wraps past 1023 to 0.
- Because A and B are fully buffered before any write, C may overlap A or B.
- `EN_NPU` falling mid-operation is ignored; the operation runs to DONE.
- `mem_rd_en` and `mem_wr_en` are never high in the same cycle.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `ack`, `mem_rd_en`, `mem_wr_en` = 0.
  - `mem_rd_addr`, `mem_wr_addr`, `mem_wdata` = 0.
  - Latched bases, counters and accumulator = 0.
- Reset mid-operation aborts immediately; no further writes or `ack`.
- All outputs are registered.
- `ack` is high in cycle `ADDR_WAIT` + 2N²+1 + N²(N+1) after the edge that samples `EN_NPU` high. For N=4 that is 117.
- The decode stage clears `EN_NPU` on the edge it samples `ack`. The earliest new start is the next rising edge of `EN_NPU`.
- The first write appears N cycles after COMPUTE entry. Consecutive writes are N+1 cycles apart.

## Structure
- Package `npu_pkg` holds:
  - the state enum;
  - default `N` and `ADDR_WAIT`;
  - widths: ADDR_W=10, DATA_W=32.
- Sub-module `npu_mat_buf`:
  - 2N²×32 register buffer;
  - one write port: index = delayed read counter;
  - two combinational read ports: A[i][k] and B[k][j].
- `npu_ctrl` holds the FSM, counters (i, j, k, load counter), MAC and memory-port registers.

## Test plan
- Identity: A=I at base 0, B={1..16} at base 16, C base 32.
  - Expect C words 32..47 = 1..16.
  - Expect `ack` at cycle 117 and 16 writes spaced 5 cycles apart.
- Signed/wrap: A all −1 (0xFFFFFFFF), B all 0x40000000.
  - Expect every C = 0x00000000, from 4·(−0x40000000) mod 2³².
- Overlap: C base = A base = 100.
  - Expect the correct product written over A.
  - Expect no read after the first write.
- Address wrap: A base 1020.
  - Expect reads at 1020..1023, then 0..11.
- Reset mid-COMPUTE: assert `rst` at cycle 60.
  - Expect outputs 0 immediately.
  - Expect no `ack`, and a clean full run on the next `EN_NPU` rising edge.
- Level hold: keep `EN_NPU` high for 5 cycles after `ack`.
  - Expect `busy`=0 and no restart until `EN_NPU` toggles 0→1.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU matrix-multiply responder.
package npu_pkg;

  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 32;
  localparam int N_DEF         = 4;
  localparam int ADDR_WAIT_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_COMP,
    S_DONE
  } state_e;

endpackage

// File: rtl/npu_mat_buf.sv
// Local A/B operand buffer: one write port, two combinational read ports.
module npu_mat_buf
  import npu_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int NN = N * N,
  localparam int NB = 2 * NN,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int BW = $clog2(NB)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [BW-1:0]     widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IW-1:0]     ai_i,
  input  logic [IW-1:0]     ak_i,
  input  logic [IW-1:0]     bk_i,
  input  logic [IW-1:0]     bj_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o
);

  logic [DATA_W-1:0] mem_q [NB];
  logic [BW-1:0]     a_idx;
  logic [BW-1:0]     b_idx;

  // A occupies words 0..NN-1, B follows at NN..2NN-1
  assign a_idx = BW'(ai_i) * BW'(N) + BW'(ak_i);
  assign b_idx = BW'(NN) + BW'(bk_i) * BW'(N) + BW'(bj_i);

  assign a_o = mem_q[a_idx];
  assign b_o = mem_q[b_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < NB; n++) begin
        mem_q[n] <= '0;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/npu_ctrl.sv
// NPU responder: latch bases, buffer A and B, MAC C = A x B, write back, ack.
module npu_ctrl
  import npu_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int ADDR_WAIT = ADDR_WAIT_DEF
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              EN_NPU,
  input  logic [ADDR_W-1:0] matA_addr,
  input  logic [ADDR_W-1:0] matB_addr,
  input  logic [ADDR_W-1:0] matC_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              ack
);

  localparam int NN = N * N;
  localparam int NB = 2 * NN;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N + 1);
  localparam int LW = $clog2(NB + 1);
  localparam int BW = $clog2(NB);
  localparam int WW = (ADDR_WAIT > 1) ? $clog2(ADDR_WAIT) : 1;

  state_e            state_q, state_d;
  logic              en_q;
  logic [WW-1:0]     wt_q, wt_d;
  logic [LW-1:0]     ld_q, ld_d;
  logic [IW-1:0]     i_q, i_d;
  logic [IW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] c_base_q, c_base_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, ack_q;
  logic              bw_q;
  logic [BW-1:0]     bidx_q;

  logic [LW-1:0]     nxt;
  logic [IW-1:0]     k_lo;
  logic [DATA_W-1:0] a_w, b_w, prod, mac;

  assign k_lo = k_q[IW-1:0];

  npu_mat_buf #(.N(N)) u_buf (
    .clk_i  (clk_50),
    .rst_i  (rst),
    .we_i   (bw_q),
    .widx_i (bidx_q),
    .wdata_i(mem_rdata),
    .ai_i   (i_q),
    .ak_i   (k_lo),
    .bk_i   (k_lo),
    .bj_i   (j_q),
    .a_o    (a_w),
    .b_o    (b_w)
  );

  // Low word of a signed product equals the low word of the unsigned one
  assign prod = a_w * b_w;
  assign mac  = ((k_q == '0) ? '0 : acc_q) + prod;
  assign nxt  = ld_q + LW'(1);

  always_comb begin
    state_d   = state_q;
    wt_d      = wt_q;
    ld_d      = ld_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        wt_d = '0;
        if (EN_NPU && !en_q) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        ld_d = '0;
        if (wt_q == WW'(ADDR_WAIT - 1)) begin
          a_base_d  = matA_addr;
          b_base_d  = matB_addr;
          c_base_d  = matC_addr;
          rd_en_d   = 1'b1;
          rd_addr_d = matA_addr;
          state_d   = S_LOAD;
        end else begin
          wt_d = wt_q + WW'(1);
        end
      end
      S_LOAD: begin
        // ld_q indexes the read currently on the bus; NB is the drain cycle
        if (ld_q == LW'(NB)) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = S_COMP;
        end else begin
          ld_d = nxt;
          if (nxt < LW'(NB)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = (nxt < LW'(NN))
                      ? a_base_q + ADDR_W'(nxt)
                      : b_base_q + ADDR_W'(nxt - LW'(NN));
          end
        end
      end
      S_COMP: begin
        if (k_q == KW'(N)) begin
          k_d = '0;
          if (j_q == IW'(N - 1)) begin
            j_d = '0;
            if (i_q == IW'(N - 1)) begin
              state_d = S_DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          acc_d = mac;
          k_d   = k_q + KW'(1);
          if (k_q == KW'(N - 1)) begin
            wr_en_d   = 1'b1;
            wdata_d   = mac;
            wr_addr_d = c_base_q
                      + ADDR_W'(i_q) * ADDR_W'(N)
                      + ADDR_W'(j_q);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      en_q      <= 1'b0;
      wt_q      <= '0;
      ld_q      <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      bw_q      <= 1'b0;
      bidx_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= EN_NPU;
      wt_q      <= wt_d;
      ld_q      <= ld_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      a_base_q  <= a_base_d;
      b_base_q  <= b_base_d;
      c_base_q  <= c_base_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= (state_d != S_IDLE);
      ack_q     <= (state_d == S_DONE);
      bw_q      <= rd_en_q;
      bidx_q    <= ld_q[BW-1:0];
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;
  assign ack         = ack_q;

endmodule

// File: tb/tb_npu_ctrl.sv
// Directed bench for npu_ctrl with a 1-cycle-latency data memory model.
module tb_npu_ctrl;
  import npu_pkg::*;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        EN_NPU;
  logic [9:0]  matA_addr, matB_addr, matC_addr;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [31:0] mem_wdata;
  logic        busy, ack;

  npu_ctrl dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .EN_NPU     (EN_NPU),
    .matA_addr  (matA_addr),
    .matB_addr  (matB_addr),
    .matC_addr  (matC_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .ack        (ack)
  );

  always #10 clk_50 = ~clk_50;

  logic [31:0] mem [1024];
  logic        pl_en;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk_50) begin
    if (mem_rd_en) mem_rdata <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wdata;
    if (pl_en)     mem[pl_addr] <= pl_data;
  end

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int nr_tot = 0, nw_tot = 0, nack_tot = 0, both_tot = 0;
  int rd_cyc_log [1024];
  int wr_cyc_log [1024];
  logic [9:0] rd_addr_log [1024];
  logic [9:0] wr_addr_log [1024];

  always @(negedge clk_50) begin
    if (mem_rd_en) begin
      rd_cyc_log[nr_tot[9:0]]  <= cyc;
      rd_addr_log[nr_tot[9:0]] <= mem_rd_addr;
      nr_tot <= nr_tot + 1;
    end
    if (mem_wr_en) begin
      wr_cyc_log[nw_tot[9:0]]  <= cyc;
      wr_addr_log[nw_tot[9:0]] <= mem_wr_addr;
      nw_tot <= nw_tot + 1;
    end
    if (ack) nack_tot <= nack_tot + 1;
    if (mem_rd_en && mem_wr_en) both_tot <= both_tot + 1;
  end

  int tests = 0;
  int fails = 0;
  int t0, nr_b, nw_b, na_b, nb_b;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk_50);
    #1 pl_en = 1'b0;
  endtask

  task automatic start(input logic [9:0] a, input logic [9:0] b,
                       input logic [9:0] c);
    matA_addr = a;
    matB_addr = b;
    matC_addr = c;
    @(negedge clk_50);
    nr_b = nr_tot; nw_b = nw_tot; na_b = nack_tot; nb_b = both_tot;
    EN_NPU = 1'b1;
    @(posedge clk_50);
    #1 t0 = cyc;
  endtask

  task automatic wait_ack(input string tag);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_50);
      if (ack) break;
    end
    chk({tag, "_ack_seen"}, 32'(ack), 32'd1);
    chk({tag, "_ack_cycle"}, 32'(cyc - t0), 32'd117);
  endtask

  task automatic check_op(input string tag, input logic [9:0] cb);
    int bad;
    chk({tag, "_nreads"}, 32'(nr_tot - nr_b), 32'd32);
    chk({tag, "_nwrites"}, 32'(nw_tot - nw_b), 32'd16);
    chk({tag, "_first_wr"}, 32'(wr_cyc_log[nw_b[9:0]] - t0), 32'd41);
    chk({tag, "_wr_addr0"}, 32'(wr_addr_log[nw_b[9:0]]), 32'(cb));
    chk({tag, "_wr_addr15"}, 32'(wr_addr_log[10'(nw_b + 15)]),
        32'(10'(cb + 10'd15)));
    bad = 0;
    for (int n = 1; n < 16; n++) begin
      if (wr_cyc_log[10'(nw_b + n)] - wr_cyc_log[10'(nw_b + n - 1)] != 5)
        bad++;
    end
    chk({tag, "_wr_spacing"}, 32'(bad), 32'd0);
    chk({tag, "_rd_wr_same"}, 32'(both_tot - nb_b), 32'd0);
    chk({tag, "_ack_once"}, 32'(nack_tot - na_b), 32'd1);
  endtask

  task automatic load_ident_and_seq(input logic [9:0] ab,
                                    input logic [9:0] bb,
                                    input logic [31:0] scale);
    for (int k = 0; k < 16; k++) begin
      poke(10'(ab + 10'(k)), (k / 4 == k % 4) ? scale : 32'd0);
      poke(10'(bb + 10'(k)), 32'(k + 1));
    end
  endtask

  initial begin
    int bad;
    int hold_rd;
    rst = 1'b1; EN_NPU = 1'b0; pl_en = 1'b0;
    pl_addr = '0; pl_data = '0;
    matA_addr = '0; matB_addr = '0; matC_addr = '0;
    repeat (3) @(negedge clk_50);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk_50);

    // Identity: A=I at 0, B=1..16 at 16, C at 32
    load_ident_and_seq(10'd0, 10'd16, 32'd1);
    for (int k = 0; k < 16; k++) poke(10'(32 + k), 32'hDEADBEEF);
    start(10'd0, 10'd16, 10'd32);
    @(negedge clk_50);
    chk("id_busy_run", 32'(busy), 32'd1);
    wait_ack("id");
    EN_NPU = 1'b0;
    repeat (3) @(negedge clk_50);
    chk("id_busy_idle", 32'(busy), 32'd0);
    check_op("id", 10'd32);
    chk("id_first_rd", 32'(rd_cyc_log[nr_b[9:0]] - t0), 32'd4);
    chk("id_last_rd", 32'(rd_cyc_log[10'(nr_b + 31)] - t0), 32'd35);
    for (int k = 0; k < 16; k++) chk("id_C", mem[32 + k], 32'(k + 1));

    // Reset in the middle of COMPUTE
    for (int k = 0; k < 16; k++) poke(10'(32 + k), 32'd0);
    start(10'd0, 10'd16, 10'd32);
    for (int n = 0; n < 200; n++) begin
      if (cyc - t0 >= 60) break;
      @(negedge clk_50);
    end
    chk("mid_cycle", 32'(cyc - t0), 32'd60);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    EN_NPU = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_wr_en", 32'(mem_wr_en), 32'd0);
    chk("mid_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mid_wdata", mem_wdata, 32'd0);
    chk("mid_wr_addr", 32'(mem_wr_addr), 32'd0);
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    nw_b = nw_tot; na_b = nack_tot; nr_b = nr_tot;
    repeat (150) @(negedge clk_50);
    chk("mid_no_ack", 32'(nack_tot - na_b), 32'd0);
    chk("mid_no_wr", 32'(nw_tot - nw_b), 32'd0);
    chk("mid_no_rd", 32'(nr_tot - nr_b), 32'd0);
    for (int k = 0; k < 16; k++) poke(10'(32 + k), 32'd0);
    start(10'd0, 10'd16, 10'd32);
    wait_ack("rerun");
    EN_NPU = 1'b0;
    repeat (3) @(negedge clk_50);
    check_op("rerun", 10'd32);
    for (int k = 0; k < 16; k++) chk("rerun_C", mem[32 + k], 32'(k + 1));

    // Signed wrap, then hold EN high after ack
    for (int k = 0; k < 16; k++) begin
      poke(10'(200 + k), 32'hFFFFFFFF);
      poke(10'(300 + k), 32'h40000000);
      poke(10'(400 + k), 32'hDEADBEEF);
    end
    start(10'd200, 10'd300, 10'd400);
    wait_ack("sgn");
    bad = 0;
    hold_rd = nr_tot;
    repeat (5) begin
      @(negedge clk_50);
      if (busy !== 1'b0) bad++;
    end
    chk("hold_busy", 32'(bad), 32'd0);
    chk("hold_no_rd", 32'(nr_tot - hold_rd), 32'd0);
    check_op("sgn", 10'd400);
    for (int k = 0; k < 16; k++) chk("sgn_C", mem[400 + k], 32'd0);
    EN_NPU = 1'b0;
    for (int k = 0; k < 16; k++) poke(10'(400 + k), 32'h12345678);
    start(10'd200, 10'd300, 10'd400);
    wait_ack("toggle");
    EN_NPU = 1'b0;
    repeat (3) @(negedge clk_50);
    check_op("toggle", 10'd400);
    chk("toggle_C0", mem[400], 32'd0);
    chk("toggle_C15", mem[415], 32'd0);

    // Overlap: C written over A (A = 2I at 100, B = 1..16 at 200)
    load_ident_and_seq(10'd100, 10'd200, 32'd2);
    start(10'd100, 10'd200, 10'd100);
    wait_ack("ovl");
    EN_NPU = 1'b0;
    repeat (3) @(negedge clk_50);
    check_op("ovl", 10'd100);
    chk("ovl_rd_before_wr",
        32'(rd_cyc_log[10'(nr_b + 31)] < wr_cyc_log[nw_b[9:0]]), 32'd1);
    for (int k = 0; k < 16; k++) chk("ovl_C", mem[100 + k], 32'(2 * (k + 1)));

    // Address wrap: A all ones at 1020 wraps to 0..11
    for (int k = 0; k < 16; k++) begin
      poke(10'(1020 + k), 32'd1);
      poke(10'(40 + k), 32'(k + 1));
    end
    start(10'd1020, 10'd40, 10'd60);
    wait_ack("wrap");
    EN_NPU = 1'b0;
    repeat (3) @(negedge clk_50);
    check_op("wrap", 10'd60);
    chk("wrap_rd3", 32'(rd_addr_log[10'(nr_b + 3)]), 32'd1023);
    chk("wrap_rd4", 32'(rd_addr_log[10'(nr_b + 4)]), 32'd0);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (rd_addr_log[10'(nr_b + k)] !==
          ((k < 16) ? 10'(1020 + k) : 10'(40 + k - 16))) bad++;
    end
    chk("wrap_rd_seq", 32'(bad), 32'd0);
    for (int k = 0; k < 16; k++)
      chk("wrap_C", mem[60 + k], 32'(28 + 4 * (k % 4)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
